// File: rtl/bada_tree_accumulator_pkg.sv
// rtl/bada_tree_accumulator_pkg.sv - shared types and defaults for the tree accumulator (package bada_acc_pkg)
package bada_acc_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        DONE  = 2'd2
    } state_e;

    // Adder-tree output width: each of the log2(N_INPUT) stages adds one carry bit.
    function automatic int tree_out_width(input int op_width, input int n_input);
        return op_width + $clog2(n_input);
    endfunction

    localparam int DEF_OP_WIDTH  = 4;
    localparam int DEF_N_INPUT   = 4;
    localparam int DEF_IN_WIDTH  = tree_out_width(DEF_OP_WIDTH, DEF_N_INPUT);
    localparam int DEF_ACC_WIDTH = 16;
    localparam int DEF_MAX_BEATS = 16;

endpackage

// File: rtl/bada_tree_accumulator_if.sv
// rtl/bada_tree_accumulator_if.sv - beat input and packet result handshake bundle
interface bada_acc_if
    import bada_acc_pkg::*;
#(
    parameter int IN_WIDTH  = DEF_IN_WIDTH,
    parameter int ACC_WIDTH = DEF_ACC_WIDTH,
    parameter int MAX_BEATS = DEF_MAX_BEATS
);
    localparam int CNT_WIDTH = $clog2(MAX_BEATS + 1);

    logic                 i_valid;
    logic [IN_WIDTH-1:0]  i_data;
    logic                 i_last;
    logic                 o_ready;
    logic                 o_valid;
    logic [ACC_WIDTH-1:0] o_data;
    logic [CNT_WIDTH-1:0] o_beats;
    logic                 o_forced;
    logic                 o_ovf;
    logic                 i_ready;

    modport master (
        output i_valid, i_data, i_last, i_ready,
        input  o_ready, o_valid, o_data, o_beats, o_forced, o_ovf
    );

    modport slave (
        input  i_valid, i_data, i_last, i_ready,
        output o_ready, o_valid, o_data, o_beats, o_forced, o_ovf
    );

endinterface

// File: rtl/bada_tree_accumulator_core.sv
// rtl/bada_tree_accumulator_core.sv - adder, overflow flag and accumulator register
// BADA_ACC_SAT_EN: clamp to all-ones on carry-out instead of wrapping.
module bada_acc_core #(
    parameter int IN_WIDTH  = 6,
    parameter int ACC_WIDTH = 16
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 load_i,
    input  logic                 first_i,
    input  logic [IN_WIDTH-1:0]  data_i,
    output logic [ACC_WIDTH-1:0] acc_o,
    output logic                 ovf_o
);
    logic [ACC_WIDTH-1:0] acc_q, acc_d;
    logic                 ovf_q, ovf_d;
    logic [ACC_WIDTH:0]   sum;
    logic                 carry;

    // The first beat of a packet ignores whatever the previous packet left behind.
    assign sum   = {1'b0, (first_i ? '0 : acc_q)}
                 + {{(ACC_WIDTH + 1 - IN_WIDTH){1'b0}}, data_i};
    assign carry = sum[ACC_WIDTH];

`ifdef BADA_ACC_SAT_EN
    assign acc_d = carry ? {ACC_WIDTH{1'b1}} : sum[ACC_WIDTH-1:0];
`else
    assign acc_d = sum[ACC_WIDTH-1:0];
`endif

    assign ovf_d = carry | (ovf_q & ~first_i);

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            acc_q <= '0;
            ovf_q <= 1'b0;
        end else if (load_i) begin
            acc_q <= acc_d;
            ovf_q <= ovf_d;
        end
    end

    assign acc_o = acc_q;
    assign ovf_o = ovf_q;

endmodule

// File: rtl/bada_tree_accumulator.sv
// rtl/bada_tree_accumulator.sv - accumulates adder-tree beats into one result per packet
// BADA_ACC_SAT_EN selects saturating accumulation in the core.
module bada_tree_accumulator
    import bada_acc_pkg::*;
#(
    parameter int IN_WIDTH  = DEF_IN_WIDTH,
    parameter int ACC_WIDTH = DEF_ACC_WIDTH,
    parameter int MAX_BEATS = DEF_MAX_BEATS
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    bada_acc_if.slave  bus
);
    localparam int CNT_WIDTH = $clog2(MAX_BEATS + 1);

    state_e               state_q;
    logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
    logic                 valid_q;
    logic                 forced_q;

    logic                 ready;
    logic                 accept;
    logic                 first;
    logic                 at_limit;
    logic                 closing;
    logic [ACC_WIDTH-1:0] acc;
    logic                 ovf;

    assign ready    = !valid_q || bus.i_ready;
    assign accept   = bus.i_valid && ready;
    assign first    = (state_q != ACCUM);
    assign cnt_d    = first ? CNT_WIDTH'(1) : cnt_q + 1'b1;
    // Only a packet already in progress can hit the limit, since MAX_BEATS >= 2.
    assign at_limit = !first && (cnt_q == CNT_WIDTH'(MAX_BEATS - 1));
    assign closing  = bus.i_last || at_limit;

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            valid_q  <= 1'b0;
            forced_q <= 1'b0;
        end else begin
            case (state_q)
                IDLE, ACCUM, DONE: begin
                    if (accept) begin
                        cnt_q <= cnt_d;
                        if (closing) begin
                            state_q  <= DONE;
                            valid_q  <= 1'b1;
                            forced_q <= !bus.i_last;
                        end else begin
                            state_q  <= ACCUM;
                            valid_q  <= 1'b0;
                            forced_q <= 1'b0;
                        end
                    end else if (state_q == DONE && bus.i_ready) begin
                        state_q <= IDLE;
                        valid_q <= 1'b0;
                    end
                end
                default: begin
                    state_q <= IDLE;
                    valid_q <= 1'b0;
                end
            endcase
        end
    end

    bada_acc_core #(
        .IN_WIDTH  (IN_WIDTH),
        .ACC_WIDTH (ACC_WIDTH)
    ) u_core (
        .clk_i   (i_clk),
        .rst_ni  (i_rst_n),
        .load_i  (accept),
        .first_i (first),
        .data_i  (bus.i_data),
        .acc_o   (acc),
        .ovf_o   (ovf)
    );

    assign bus.o_ready  = ready;
    assign bus.o_valid  = valid_q;
    assign bus.o_data   = acc;
    assign bus.o_beats  = cnt_q;
    assign bus.o_forced = forced_q;
    assign bus.o_ovf    = ovf;

endmodule

// File: tb/tb_bada_tree_accumulator.sv
// tb/tb_bada_tree_accumulator.sv - randomized and directed checks of two accumulator widths
module tb_bada_tree_accumulator;
    localparam int MAXB = 16;
`ifdef BADA_ACC_SAT_EN
    localparam int OVF8_DATA = 255;
`else
    localparam int OVF8_DATA = 59;
`endif

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       i_valid = 1'b0;
    logic [5:0] i_data = '0;
    logic       i_last = 1'b0;
    logic       i_ready = 1'b1;
    bit         rand_ready = 1'b0;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        int tot;
        int nb;
        bit forced;
    } exp_t;
    exp_t exp_q[$];
    int   m_tot = 0;
    int   m_nb  = 0;

    bada_acc_if #(.IN_WIDTH(6), .ACC_WIDTH(16), .MAX_BEATS(MAXB)) bus16 ();
    bada_acc_if #(.IN_WIDTH(6), .ACC_WIDTH(8),  .MAX_BEATS(MAXB)) bus8 ();

    assign bus16.i_valid = i_valid;
    assign bus16.i_data  = i_data;
    assign bus16.i_last  = i_last;
    assign bus16.i_ready = i_ready;
    assign bus8.i_valid  = i_valid;
    assign bus8.i_data   = i_data;
    assign bus8.i_last   = i_last;
    assign bus8.i_ready  = i_ready;

    bada_tree_accumulator #(.IN_WIDTH(6), .ACC_WIDTH(16), .MAX_BEATS(MAXB)) dut16 (
        .i_clk (clk), .i_rst_n (rst_n), .bus (bus16)
    );
    bada_tree_accumulator #(.IN_WIDTH(6), .ACC_WIDTH(8), .MAX_BEATS(MAXB)) dut8 (
        .i_clk (clk), .i_rst_n (rst_n), .bus (bus8)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0d exp=%0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic int exp_data(input int tot, input int w);
`ifdef BADA_ACC_SAT_EN
        if (tot >= (1 << w)) return (1 << w) - 1;
`endif
        return tot % (1 << w);
    endfunction

    // Packet rules: a packet ends on i_last or after MAXB beats, whichever comes first.
    task automatic model_beat(input int d, input bit last);
        exp_t e;
        m_tot += d;
        m_nb++;
        if (last || m_nb == MAXB) begin
            e.tot = m_tot;
            e.nb = m_nb;
            e.forced = !last;
            exp_q.push_back(e);
            m_tot = 0;
            m_nb = 0;
        end
    endtask

    task automatic send_beat(input int d, input bit last);
        bit ok;
        ok = 1'b0;
        i_valid = 1'b1;
        i_data = d[5:0];
        i_last = last;
        for (int t = 0; t < 1000 && !ok; t++) begin
            @(negedge clk);
            ok = bus16.o_ready;
            @(posedge clk);
            #1;
        end
        i_valid = 1'b0;
        i_last = 1'b0;
        if (ok) model_beat(d, last);
        else check("beat_timeout", 0, 1);
    endtask

    task automatic idle(input int n);
        i_valid = 1'b0;
        repeat (n) begin
            i_last = 1'($urandom_range(0, 1));
            i_data = 6'($urandom);
            @(posedge clk);
            #1;
        end
        i_last = 1'b0;
    endtask

    always @(posedge clk) begin
        #1;
        if (rand_ready) i_ready = ($urandom_range(0, 3) != 0);
    end

    bit          stall_prev = 1'b0;
    logic [15:0] held_data;
    logic [4:0]  held_beats;
    logic        held_forced, held_ovf;

    always @(negedge clk) begin
        exp_t e;
        if (!rst_n) begin
            stall_prev = 1'b0;
        end else begin
            check("ready_rule16", bus16.o_ready, !bus16.o_valid || i_ready);
            check("ready_rule8", bus8.o_ready, !bus8.o_valid || i_ready);
            if (stall_prev) begin
                check("stall_valid", bus16.o_valid, 1);
                check("stall_data", bus16.o_data, held_data);
                check("stall_beats", bus16.o_beats, held_beats);
                check("stall_forced", bus16.o_forced, held_forced);
                check("stall_ovf", bus16.o_ovf, held_ovf);
            end
            stall_prev = bus16.o_valid && !i_ready;
            held_data = bus16.o_data;
            held_beats = bus16.o_beats;
            held_forced = bus16.o_forced;
            held_ovf = bus16.o_ovf;
            if (bus16.o_valid && i_ready) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_result", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("data16", bus16.o_data, exp_data(e.tot, 16));
                    check("beats16", bus16.o_beats, e.nb);
                    check("forced16", bus16.o_forced, e.forced);
                    check("ovf16", bus16.o_ovf, e.tot >= 65536);
                    check("valid8", bus8.o_valid, 1);
                    check("data8", bus8.o_data, exp_data(e.tot, 8));
                    check("beats8", bus8.o_beats, e.nb);
                    check("forced8", bus8.o_forced, e.forced);
                    check("ovf8", bus8.o_ovf, e.tot >= 256);
                end
            end
        end
    end

    task automatic check_reset_outputs(input string tag);
        check({tag, "_valid"}, bus16.o_valid, 0);
        check({tag, "_data"}, bus16.o_data, 0);
        check({tag, "_beats"}, bus16.o_beats, 0);
        check({tag, "_forced"}, bus16.o_forced, 0);
        check({tag, "_ovf"}, bus16.o_ovf, 0);
        check({tag, "_ready"}, bus16.o_ready, 1);
        check({tag, "_valid8"}, bus8.o_valid, 0);
        check({tag, "_data8"}, bus8.o_data, 0);
    endtask

    initial begin
        #1 rst_n = 1'b0;
        #1 check_reset_outputs("reset");
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        idle(1);

        // 4+4+4 closed by i_last, result the very next cycle
        send_beat(4, 0);
        send_beat(4, 0);
        send_beat(4, 1);
        @(negedge clk);
        check("lat_valid", bus16.o_valid, 1);
        check("lat_data", bus16.o_data, 12);
        check("lat_beats", bus16.o_beats, 3);
        check("lat_forced", bus16.o_forced, 0);
        check("lat_ovf", bus16.o_ovf, 0);
        @(posedge clk); #1;

        send_beat(63, 1);
        @(negedge clk);
        check("single_data", bus16.o_data, 63);
        check("single_beats", bus16.o_beats, 1);
        @(posedge clk); #1;

        for (int b = 0; b < MAXB; b++) send_beat(5, 0);
        @(negedge clk);
        check("forced_valid", bus16.o_valid, 1);
        check("forced_data", bus16.o_data, 80);
        check("forced_beats", bus16.o_beats, 16);
        check("forced_flag", bus16.o_forced, 1);
        @(posedge clk); #1;
        send_beat(5, 1);
        @(negedge clk);
        check("beat17_data", bus16.o_data, 5);
        check("beat17_beats", bus16.o_beats, 1);
        check("beat17_forced", bus16.o_forced, 0);
        @(posedge clk); #1;

        // downstream stall, then release together with a new closing beat
        i_ready = 1'b0;
        send_beat(3, 1);
        repeat (5) begin
            @(negedge clk);
            check("stall_ready", bus16.o_ready, 0);
            @(posedge clk); #1;
        end
        i_ready = 1'b1;
        send_beat(7, 1);
        @(negedge clk);
        check("b2b_valid", bus16.o_valid, 1);
        check("b2b_data", bus16.o_data, 7);
        @(posedge clk); #1;

        for (int b = 0; b < 5; b++) send_beat(63, b == 4);
        @(negedge clk);
        check("ovf8_flag", bus8.o_ovf, 1);
        check("ovf8_data", bus8.o_data, OVF8_DATA);
        check("ovf16_data", bus16.o_data, 315);
        check("ovf16_flag", bus16.o_ovf, 0);
        @(posedge clk); #1;

        // asynchronous reset in the middle of a packet
        send_beat(10, 0);
        send_beat(20, 0);
        #2 rst_n = 1'b0;
        #1 check_reset_outputs("midrst");
        m_tot = 0;
        m_nb = 0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        send_beat(6, 1);
        @(negedge clk);
        check("after_rst_data", bus16.o_data, 6);
        check("after_rst_beats", bus16.o_beats, 1);
        @(posedge clk); #1;

        rand_ready = 1'b1;
        for (int p = 0; p < 150; p++) begin
            int len;
            len = $urandom_range(1, 20);
            for (int b = 0; b < len; b++) begin
                send_beat($urandom_range(0, 63), b == len - 1);
                if ($urandom_range(0, 5) == 0) idle($urandom_range(1, 3));
            end
        end

        @(negedge clk);
        rand_ready = 1'b0;
        i_ready = 1'b1;
        for (int t = 0; t < 100 && exp_q.size() != 0; t++) @(negedge clk);
        check("drain_empty", exp_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
